// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multi-cycle RV32I core: steps FETCH/DECODE/EXEC/MEM/WB over a shared
// variable-latency memory port, traps on illegal opcodes or memory stalls, and counts retirements.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int RET_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [4:0]       rd,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_src,
    output logic             alu_src_b,
    output logic             imm_sel,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             wb_src,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) + 1 : 1;

    state_e            state_q, state_d;
    logic [1:0]        cause_q, cause_d;
    logic [RET_W-1:0]  retired_q, retired_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              retire;

    logic is_r, is_i, is_load, is_store, is_branch, illegal;
    logic mem_wait, wd_expire;

    // funct3 is consumed directly by the ALU decoder; the sequencer never needs it.
    logic unused_funct3;
    assign unused_funct3 = ^funct3;

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign illegal   = !(is_r || is_i || is_load || is_store || is_branch)
                     || (is_r && (funct7 != 7'b0000000) && (funct7 != 7'b0100000));

    // A cycle counts toward the watchdog only while a request is outstanding and unanswered.
    assign mem_wait  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
    assign wd_expire = (MEM_TIMEOUT != 0) && mem_wait && (wd_q == WD_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_START;
            cause_q   <= 2'b00;
            retired_q <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
            wd_q      <= wd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        retire    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_src  = 1'b0;
        alu_src_b = 1'b0;
        imm_sel   = 1'b0;
        alu_op    = 2'b00;
        reg_write = 1'b0;
        wb_src    = 1'b0;
        trap      = 1'b0;

        case (state_q)
            ST_START: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (wd_expire) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (illegal) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_r) begin
                    alu_op  = 2'b10;
                    state_d = ST_WB;
                end else if (is_i) begin
                    alu_src_b = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = ST_WB;
                end else if (is_load || is_store) begin
                    alu_src_b = 1'b1;
                    imm_sel   = is_store;
                    state_d   = ST_MEM;
                end else begin
                    alu_op   = 2'b01;
                    pc_write = 1'b1;
                    pc_src   = branch_taken;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
                mem_we   = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wd_expire) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_WB: begin
                reg_write = (rd != 5'd0);
                wb_src    = is_load;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_TRAP: trap = 1'b1;
            default: state_d = ST_START;
        endcase

        retired_d = retire ? retired_q + RET_W'(1) : retired_q;
        wd_d      = (state_d != state_q) ? '0 : (mem_wait ? wd_q + WD_W'(1) : wd_q);
    end

    assign trap_cause = cause_q;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule
